a2d_scan_ctrl: RTL

SPI master and channel scheduler for the ADC128S 8-channel, 12-bit A2D. While enabled, it scans the channels in a mask round-robin, issuing back-to-back 16-bit SPI frames. It accounts for the converter's one-frame pipeline, in which the data returned in a frame belongs to the channel addressed in the previous frame. Results go to an 8-entry result register file with a valid pulse, for use by the sensor/motor control logic.

---
 rtl/a2d_scan_ctrl.sv | 179 +++++++++++++++++
 1 files changed

// File: rtl/a2d_scan_ctrl.sv
// a2d_scan_ctrl: SPI master and round-robin channel scheduler for an ADC128S 8-channel 12-bit A2D.
// Ports: clk, rst (asynchronous, active-high)
//        en, chnl_mask       : scan enable and set of channels to scan
//        SS_n, SCLK, MOSI    : SPI outputs to the A2D (SCLK idles high)
//        MISO                : SPI data from the A2D
//        rd_chnl, rd_data    : combinational read port of the 8-entry result file
//        res_chnl, res_data  : channel and value of the most recent result
//        res_vld             : one-clk pulse when res_chnl/res_data update
//        busy                : high whenever the frame FSM is not idle
// Optional: define A2D_AVG_EN to store the rounded average of the new sample and the stored value.
module a2d_scan_ctrl #(
    parameter int SCLK_DIV = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        en,
    input  logic [7:0]  chnl_mask,
    output logic        SS_n,
    output logic        SCLK,
    output logic        MOSI,
    input  logic        MISO,
    input  logic [2:0]  rd_chnl,
    output logic [11:0] rd_data,
    output logic [2:0]  res_chnl,
    output logic [11:0] res_data,
    output logic        res_vld,
    output logic        busy
);
    typedef enum logic [2:0] {IDLE, FRONT, SHIFT, BACK, GAP} state_t;
    localparam logic [8:0] HALF = 9'(SCLK_DIV - 1);
    localparam logic [8:0] FULL = 9'(2 * SCLK_DIV - 1);
    state_t      state_q, state_d;
    logic [8:0]  cnt_q, cnt_d;
    logic [3:0]  bit_q, bit_d;
    logic [15:0] tx_q, tx_d;
    logic [11:0] rx_q, rx_d;
    logic        ss_n_q, ss_n_d, sclk_q, sclk_d;
    logic [2:0]  cur_ch_q, cur_ch_d, frm_ch_q, frm_ch_d, prev_ch_q, prev_ch_d;
    logic        flush_q, flush_d, pend_q, pend_d;
    logic [2:0]  res_chnl_q, res_chnl_d;
    logic [11:0] res_data_q, res_data_d;
    logic        res_vld_q, res_vld_d;
    logic [11:0] mem_q [8];
    logic        wr_en;
    logic [11:0] wr_val;
    logic        scan, start;
    logic [2:0]  nxt_ch, frm_sel;
    assign scan    = en && (chnl_mask != 8'd0);
    assign start   = scan || pend_q;
    assign frm_sel = scan ? nxt_ch : 3'd0;
    // Iterate downward so the nearest set bit after cur_ch wins; offset 8 wraps to cur_ch itself.
    always_comb begin
        nxt_ch = cur_ch_q;
        for (int k = 8; k >= 1; k--)
            if (chnl_mask[cur_ch_q + 3'(k)]) nxt_ch = cur_ch_q + 3'(k);
    end
`ifdef A2D_AVG_EN
    logic [7:0]  seen_q;
    logic [12:0] sum;
    assign sum    = 13'(mem_q[prev_ch_q]) + 13'(rx_q) + 13'd1;
    assign wr_val = seen_q[prev_ch_q] ? sum[12:1] : rx_q;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) seen_q <= '0;
        else if (wr_en) seen_q[prev_ch_q] <= 1'b1;
    end
`else
    assign wr_val = rx_q;
`endif
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q + 9'd1;
        bit_d      = bit_q;
        tx_d       = tx_q;
        rx_d       = rx_q;
        ss_n_d     = ss_n_q;
        sclk_d     = sclk_q;
        cur_ch_d   = cur_ch_q;
        frm_ch_d   = frm_ch_q;
        prev_ch_d  = prev_ch_q;
        flush_d    = flush_q;
        pend_d     = pend_q;
        res_chnl_d = res_chnl_q;
        res_data_d = res_data_q;
        res_vld_d  = 1'b0;
        wr_en      = 1'b0;
        case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (start) begin
                    state_d  = FRONT;
                    ss_n_d   = 1'b0;
                    bit_d    = '0;
                    frm_ch_d = frm_sel;
                    flush_d  = !scan;
                    cur_ch_d = scan ? nxt_ch : cur_ch_q;
                    tx_d     = {2'b00, frm_sel, 11'h000};
                end
            end
            FRONT: if (cnt_q == HALF) begin
                state_d = SHIFT;
                cnt_d   = '0;
                sclk_d  = 1'b0;
            end
            SHIFT: begin
                if (cnt_q == HALF) begin
                    sclk_d = 1'b1;
                    rx_d   = {rx_q[10:0], MISO};
                end
                if (cnt_q == FULL) begin
                    cnt_d = '0;
                    if (bit_q == 4'd15) state_d = BACK;
                    else begin
                        sclk_d = 1'b0;
                        tx_d   = {tx_q[14:0], 1'b0};
                        bit_d  = bit_q + 4'd1;
                    end
                end
            end
            BACK: if (cnt_q == HALF) begin
                state_d    = GAP;
                cnt_d      = '0;
                ss_n_d     = 1'b1;
                wr_en      = pend_q;
                res_vld_d  = pend_q;
                res_chnl_d = pend_q ? prev_ch_q : res_chnl_q;
                res_data_d = pend_q ? wr_val : res_data_q;
                prev_ch_d  = frm_ch_q;
                pend_d     = !flush_q;
            end
            GAP: if (cnt_q == HALF) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            bit_q      <= '0;
            tx_q       <= '0;
            rx_q       <= '0;
            ss_n_q     <= 1'b1;
            sclk_q     <= 1'b1;
            cur_ch_q   <= 3'd7;
            frm_ch_q   <= '0;
            prev_ch_q  <= '0;
            flush_q    <= 1'b0;
            pend_q     <= 1'b0;
            res_chnl_q <= '0;
            res_data_q <= '0;
            res_vld_q  <= 1'b0;
            for (int i = 0; i < 8; i++) mem_q[i] <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            bit_q      <= bit_d;
            tx_q       <= tx_d;
            rx_q       <= rx_d;
            ss_n_q     <= ss_n_d;
            sclk_q     <= sclk_d;
            cur_ch_q   <= cur_ch_d;
            frm_ch_q   <= frm_ch_d;
            prev_ch_q  <= prev_ch_d;
            flush_q    <= flush_d;
            pend_q     <= pend_d;
            res_chnl_q <= res_chnl_d;
            res_data_q <= res_data_d;
            res_vld_q  <= res_vld_d;
            if (wr_en) mem_q[prev_ch_q] <= wr_val;
        end
    end
    assign SS_n     = ss_n_q;
    assign SCLK     = sclk_q;
    assign MOSI     = tx_q[15];
    assign rd_data  = mem_q[rd_chnl];
    assign res_chnl = res_chnl_q;
    assign res_data = res_data_q;
    assign res_vld  = res_vld_q;
    assign busy     = state_q != IDLE;
endmodule
